// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the RV32 datapath: steps each instruction
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and gates the control word per state.
module multicycle_sequencer (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [4:0]  opcodeIn,
  input  logic [11:0] ctrSignalsIn,
  input  logic        memReadyIn,
  output logic        imemReqOut,
  output logic        irWriteOut,
  output logic        pcWriteOut,
  output logic [11:0] ctrSignalsOut,
  output logic [2:0]  stateOut,
  output logic        haltOut,
  output logic [31:0] cycleCountOut,
  output logic [31:0] instrCountOut
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } stateT;

  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  stateT       state;
  logic [11:0] ctrlReg;
  logic [31:0] cycleCnt;
  logic [31:0] instrCnt;

  logic isMemOp, isRegWr, counted, pcWrite;

  assign isMemOp = ctrlReg[8] | ctrlReg[7];
  assign isRegWr = ctrlReg[11];
  assign counted = (state == FETCH) || (state == DECODE) || (state == EXECUTE) ||
                   (state == MEMORY) || (state == WRITEBACK);

  // One PC strobe per retired instruction, on the cycle whose edge re-enters FETCH.
  always_comb begin
    pcWrite = 1'b0;
    case (state)
      EXECUTE:   pcWrite = !isMemOp && !isRegWr;
      MEMORY:    pcWrite = memReadyIn && !isRegWr;
      WRITEBACK: pcWrite = 1'b1;
      default:   pcWrite = 1'b0;
    endcase
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state    <= IDLE;
      ctrlReg  <= '0;
      cycleCnt <= '0;
      instrCnt <= '0;
    end else begin
      if (counted) cycleCnt <= cycleCnt + 32'd1;
      if (pcWrite) instrCnt <= instrCnt + 32'd1;
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   if (memReadyIn) state <= DECODE;
        DECODE: begin
          ctrlReg <= ctrSignalsIn;
          state   <= (opcodeIn == OP_SYSTEM) ? HALT : EXECUTE;
        end
        EXECUTE: begin
          if (isMemOp)      state <= MEMORY;
          else if (isRegWr) state <= WRITEBACK;
          else              state <= FETCH;
        end
        MEMORY:    if (memReadyIn) state <= isRegWr ? WRITEBACK : FETCH;
        WRITEBACK: state <= FETCH;
        HALT:      state <= HALT;
        default:   state <= IDLE;
      endcase
    end
  end

  assign imemReqOut    = (state == FETCH);
  assign irWriteOut    = (state == FETCH) && memReadyIn;
  assign pcWriteOut    = pcWrite;
  assign haltOut       = (state == HALT);
  assign stateOut      = state;
  assign cycleCountOut = cycleCnt;
  assign instrCountOut = instrCnt;

  // RegWrite only in WRITEBACK, MemRead/MemWrite only in MEMORY; muxes pass through.
  assign ctrSignalsOut = {(state == WRITEBACK) & ctrlReg[11],
                          ctrlReg[10:9],
                          (state == MEMORY) ? ctrlReg[8:7] : 2'b00,
                          ctrlReg[6:0]};

endmodule
